fifo_pop_stream: RTL and testbench
==================================

// Module: fifo_pop_stream
// PURPOSE
//  Read-side adapter for a pop-interface FIFO (empty/pop/data). Drains the FIFO into a
//  registered valid/ready stream through a 2-entry output buffer (head + skid).
//  Sits between a FIFO and any stream consumer. ready_i has no combinational path to pop_o.
//  Sustains 1 beat/cycle when the FIFO is non-empty and the consumer is ready.
// PARAMETERS
//  DATA_WIDTH  32  width of the FIFO data word and the stream payload
//  STAT_WIDTH  16  width of the statistics counters (used only with the stats option)
// PORTS
//  clk_i         in   1           clock
//  rst_ni        in   1           reset, asynchronous, active-low
//  flush_i       in   1           synchronous flush of the buffered entries
//  empty_i       in   1           FIFO empty flag
//  fifo_data_i   in   DATA_WIDTH  FIFO head data; valid when empty_i=0
//  pop_o         out  1           pop strobe to the FIFO; head is consumed this cycle
//  valid_o       out  1           stream valid
//  ready_i       in   1           stream ready
//  data_o        out  DATA_WIDTH  stream payload, registered
//  beat_cnt_o    out  STAT_WIDTH  accepted beats (stats option)
//  stall_cnt_o   out  STAT_WIDTH  cycles with valid_o=1 and ready_i=0 (stats option)
// BEHAVIOUR
//  - Reset: cnt_q=0, head_q=skid_q='0, valid_o=0, data_o='0, stats=0.
//  - pop_o = ~empty_i & ~flush_i & (cnt_q != 2). pop_o is never high while empty_i=1.
//    It depends only on registered state, empty_i and flush_i.
//  - Occupancy FSM, cnt_q in {EMPTY=0, ONE=1, TWO=2}.
//    The stream handshake xfer = valid_o & ready_i. valid_o = (cnt_q != 0). data_o = head_q.
//    - EMPTY:
//      - pop: head_q <= fifo_data_i, go to ONE.
//      - otherwise stay in EMPTY.
//    - ONE:
//      - pop & xfer: head_q <= fifo_data_i, stay in ONE.
//      - pop & ~xfer: skid_q <= fifo_data_i, go to TWO.
//      - ~pop & xfer: go to EMPTY.
//      - otherwise hold.
//    - TWO: pop_o=0.
//      - xfer: head_q <= skid_q, go to ONE.
//      - otherwise hold.
//    - Encoding 3 is unreachable; if it is reached, go to EMPTY.
//  - Latency: FIFO head is on data_o the cycle after the pop. valid_o rises 1 cycle after the
//    first pop from EMPTY.
//  - Stream rule: while valid_o=1 & ready_i=0, data_o and valid_o are held stable.
//    No beat is dropped, duplicated or reordered.
//  - Full throughput: in ONE with ready_i=1 and the FIFO non-empty, one beat moves per cycle.
//  - FIFO goes empty mid-burst: pop_o drops that cycle. Buffered beats still drain.
//  - flush_i=1: pop_o=0 that cycle. Next cycle cnt_q=0 and valid_o=0, regardless of xfer.
//    Buffered data is discarded; head_q/skid_q need not be cleared.
//    If valid_o=1 & ready_i=1 in the flush cycle, that beat counts as accepted.
//  - Async reset mid-transfer: all state returns to reset values immediately.
//    The FIFO is reset by the same rst_ni.
// CONFIGURATION
//  - Macro FIFO_POP_STREAM_STATS_EN defined:
//    - beat_cnt_o increments on each xfer.
//    - stall_cnt_o increments each cycle with valid_o & ~ready_i.
//    - Both counters saturate at all-ones and are cleared by reset and by flush_i.
//  - Macro not defined: the ports remain; beat_cnt_o and stall_cnt_o are tied to '0 and no
//    counter flops are generated.
// TESTING
//  - Reset then idle, empty_i=1 -> pop_o=0, valid_o=0, data_o=0 for 10 cycles.
//  - FIFO holds 0xA,0xB,0xC; ready_i=1 throughout.
//    -> pops in cycles 0-2; data_o = 0xA,0xB,0xC in cycles 1-3; valid_o falls in cycle 4.
//  - FIFO holds 4 words; ready_i=0 -> exactly 2 pops, then pop_o=0.
//    data_o holds word0 stable; after ready_i=1, the 4 words leave in order.
//  - Steady state with 1 entry buffered; toggle ready_i 1,0,1,0 -> each beat is accepted
//    exactly once, in order, with no loss.
//  - 2 entries buffered, flush_i=1 for 1 cycle -> pop_o=0 that cycle; valid_o=0 the next
//    cycle; the next FIFO word appears as a fresh first beat.
//  - STATS_EN, STAT_WIDTH=4: 20 accepted beats -> beat_cnt_o=15 (saturated).
//    3 stall cycles -> stall_cnt_o=3. Macro undefined -> both read 0.

Source files
------------

// File: rtl/fifo_pop_stream.sv
// fifo_pop_stream: drains a pop-interface FIFO into a registered valid/ready stream
// through a two-entry buffer (head + skid), so ready_i never reaches pop_o combinationally.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   flush_i               discard buffered entries (synchronous)
//   empty_i, fifo_data_i  FIFO side: empty flag and head word
//   pop_o                 pop strobe, FIFO head consumed this cycle
//   valid_o, ready_i      stream handshake
//   data_o                stream payload (registered head entry)
//   beat_cnt_o            saturating count of accepted beats
//   stall_cnt_o           saturating count of valid-but-not-ready cycles
// Optional feature: define FIFO_POP_STREAM_STATS_EN to build the statistics counters;
// without it the two counter ports are tied to zero.
module fifo_pop_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  pop_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [STAT_WIDTH-1:0] beat_cnt_o,
    output logic [STAT_WIDTH-1:0] stall_cnt_o
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t                cnt_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  pop;
    logic                  xfer;

    // Popping is gated only by occupancy, so a full buffer never depends on ready_i.
    assign pop     = ~empty_i & ~flush_i & (cnt_q != TWO);
    assign pop_o   = pop;
    assign valid_o = cnt_q != EMPTY;
    assign data_o  = head_q;
    assign xfer    = valid_o & ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= EMPTY;
            head_q <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            cnt_q <= EMPTY;
        end else begin
            case (cnt_q)
                EMPTY: begin
                    if (pop) begin
                        head_q <= fifo_data_i;
                        cnt_q  <= ONE;
                    end
                end
                ONE: begin
                    if (pop && xfer) begin
                        head_q <= fifo_data_i;
                    end else if (pop) begin
                        skid_q <= fifo_data_i;
                        cnt_q  <= TWO;
                    end else if (xfer) begin
                        cnt_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        head_q <= skid_q;
                        cnt_q  <= ONE;
                    end
                end
                default: cnt_q <= EMPTY;
            endcase
        end
    end

`ifdef FIFO_POP_STREAM_STATS_EN
    logic [STAT_WIDTH-1:0] beat_q;
    logic [STAT_WIDTH-1:0] stall_q;

    // Flush clears the counters even if a beat is accepted in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q  <= '0;
            stall_q <= '0;
        end else if (flush_i) begin
            beat_q  <= '0;
            stall_q <= '0;
        end else begin
            if (xfer && !(&beat_q)) beat_q <= beat_q + STAT_WIDTH'(1);
            if (valid_o && !ready_i && !(&stall_q)) stall_q <= stall_q + STAT_WIDTH'(1);
        end
    end

    assign beat_cnt_o  = beat_q;
    assign stall_cnt_o = stall_q;
`else
    assign beat_cnt_o  = '0;
    assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fifo_pop_stream.sv
// tb_fifo_pop_stream: self-checking bench for fifo_pop_stream with a FIFO model and
// a scoreboard of popped words awaiting acceptance on the stream.
module tb_fifo_pop_stream;
    localparam int DW  = 8;
    localparam int SW  = 4;
    localparam int MAX = (1 << SW) - 1;
`ifdef FIFO_POP_STREAM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          empty_i = 1'b1;
    logic [DW-1:0] fifo_data_i = '0;
    logic          pop_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [DW-1:0] data_o;
    logic [SW-1:0] beat_cnt_o;
    logic [SW-1:0] stall_cnt_o;

    always #5 clk_i = ~clk_i;

    fifo_pop_stream #(.DATA_WIDTH(DW), .STAT_WIDTH(SW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .empty_i(empty_i),
        .fifo_data_i(fifo_data_i), .pop_o(pop_o), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o), .beat_cnt_o(beat_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    typedef struct {
        logic          rdy;
        logic          fl;
        logic          pop;
        logic          vld;
        logic [DW-1:0] data;
    } vec_t;

    logic [DW-1:0] fifo[$];
    logic [DW-1:0] sb[$];
    vec_t          t_abc[5];
    vec_t          t_stall[9];
    int            nchk = 0;
    int            nerr = 0;
    int            beat_m = 0;
    int            stall_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rdy, input logic fl);
        ready_i     = rdy;
        flush_i     = fl;
        empty_i     = fifo.size() == 0;
        fifo_data_i = empty_i ? '0 : fifo[0];
        #1;
    endtask

    task automatic advance();
        logic pop_e;
        logic vld_e;
        logic xfer;
        pop_e = !empty_i && !flush_i && sb.size() < 2;
        vld_e = sb.size() != 0;
        xfer  = vld_e && ready_i;
        chk("pop_o", 32'(pop_o), 32'(pop_e));
        chk("valid_o", 32'(valid_o), 32'(vld_e));
        if (vld_e) chk("data_o", 32'(data_o), 32'(sb[0]));
        chk("beat_cnt_o", 32'(beat_cnt_o), STATS ? beat_m : 0);
        chk("stall_cnt_o", 32'(stall_cnt_o), STATS ? stall_m : 0);
        @(posedge clk_i);
        if (xfer) void'(sb.pop_front());
        if (pop_e) sb.push_back(fifo.pop_front());
        if (flush_i) begin
            sb.delete();
            beat_m  = 0;
            stall_m = 0;
        end else begin
            if (xfer && beat_m < MAX) beat_m++;
            if (vld_e && !ready_i && stall_m < MAX) stall_m++;
        end
        @(negedge clk_i);
    endtask

    task automatic cycle(input logic rdy, input logic fl);
        drive(rdy, fl);
        advance();
    endtask

    task automatic run_vec(input vec_t v, input string name);
        drive(v.rdy, v.fl);
        chk({name, "_pop"}, 32'(pop_o), 32'(v.pop));
        chk({name, "_valid"}, 32'(valid_o), 32'(v.vld));
        if (v.vld) chk({name, "_data"}, 32'(data_o), 32'(v.data));
        advance();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (sb.size() != 0 || fifo.size() != 0); i++) cycle(1'b1, 1'b0);
        chk("drain_done", 32'(sb.size() + fifo.size()), 32'd0);
    endtask

    initial begin
        t_abc = '{
            '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
            '{1'b1, 1'b0, 1'b1, 1'b1, 8'h0A},
            '{1'b1, 1'b0, 1'b1, 1'b1, 8'h0B},
            '{1'b1, 1'b0, 1'b0, 1'b1, 8'h0C},
            '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00}
        };
        t_stall = '{
            '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
            '{1'b0, 1'b0, 1'b1, 1'b1, 8'h11},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'h11},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'h11},
            '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11},
            '{1'b1, 1'b0, 1'b1, 1'b1, 8'h12},
            '{1'b1, 1'b0, 1'b1, 1'b1, 8'h13},
            '{1'b1, 1'b0, 1'b0, 1'b1, 8'h14},
            '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00}
        };

        #1;
        chk("rst_pop", 32'(pop_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_beat", 32'(beat_cnt_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0);
            chk("idle_data", 32'(data_o), 32'd0);
            advance();
        end

        fifo = '{8'h0A, 8'h0B, 8'h0C};
        foreach (t_abc[i]) run_vec(t_abc[i], "abc");

        fifo = '{8'h11, 8'h12, 8'h13, 8'h14};
        foreach (t_stall[i]) run_vec(t_stall[i], "stall");

        fifo = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(i % 2 == 0, 1'b0);
        drain();

        fifo = '{8'h31, 8'h32, 8'h33};
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        chk("flush_pop", 32'(pop_o), 32'd0);
        advance();
        drive(1'b0, 1'b0);
        chk("flush_valid", 32'(valid_o), 32'd0);
        advance();
        drive(1'b1, 1'b0);
        chk("fresh_valid", 32'(valid_o), 32'd1);
        chk("fresh_data", 32'(data_o), 32'h33);
        advance();
        drain();

        fifo = '{8'h51, 8'h52, 8'h53};
        cycle(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_data", 32'(data_o), 32'd0);
        chk("arst_beat", 32'(beat_cnt_o), 32'd0);
        sb.delete();
        fifo.delete();
        beat_m  = 0;
        stall_m = 0;
        empty_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle(1'b1, 1'b0);

        cycle(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) fifo.push_back(8'(8'h60 + i));
        drain();
        drive(1'b1, 1'b0);
        chk("beat_sat", 32'(beat_cnt_o), STATS ? 32'd15 : 32'd0);
        advance();
        fifo = '{8'h7F};
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        chk("stall_3", 32'(stall_cnt_o), STATS ? 32'd3 : 32'd0);
        advance();
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
